// File: rtl/sat_alu_seq.sv
// sat_alu_seq: registered saturating ALU with N/Z/V flags and an optional shift-add signed multiply.
// Define SAT_ALU_MUL_EN to build the multi-cycle multiplier; otherwise op 8 is a single-cycle NOP.
module sat_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] src0,
    input  logic [WIDTH-1:0] src1,
    input  logic [SHW-1:0]   shamt,
    input  logic             flag_we,
    output logic             out_valid,
    output logic [WIDTH-1:0] dst,
    output logic [2:0]       flags
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_NOR = 4'd3;
    localparam logic [3:0] OP_SLL = 4'd4, OP_SRL = 4'd5, OP_SRA = 4'd6, OP_LHB = 4'd7;
    localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] dst_q, dst_d, add_res, sra_res, alu_res;
    logic [2:0]       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH:0]   sum;
    logic             accept, is_mul, is_arith, is_logic, sat_pos, sat_neg;

    assign accept   = in_valid & in_ready;
    assign sum      = op == OP_SUB ? {src0[WIDTH-1], src0} - {src1[WIDTH-1], src1}
                                   : {src0[WIDTH-1], src0} + {src1[WIDTH-1], src1};
    assign sat_pos  = sum[WIDTH:WIDTH-1] == 2'b01;
    assign sat_neg  = sum[WIDTH:WIDTH-1] == 2'b10;
    assign add_res  = sat_pos ? MAXV : sat_neg ? MINV : sum[WIDTH-1:0];
    assign sra_res  = $signed(src0) >>> shamt;
    assign is_arith = op == OP_ADD || op == OP_SUB;
    assign is_logic = op >= OP_AND && op <= OP_SRA;
    assign alu_res  = is_arith     ? add_res :
                      op == OP_AND ? src0 & src1 :
                      op == OP_NOR ? ~(src0 | src1) :
                      op == OP_SLL ? src0 << shamt :
                      op == OP_SRL ? src0 >> shamt :
                      op == OP_SRA ? sra_res :
                      op == OP_LHB ? {src1[WIDTH/2-1:0], src0[WIDTH/2-1:0]} : dst_q;

`ifdef SAT_ALU_MUL_EN
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
    localparam logic [2*WIDTH-1:0] HALF = {{WIDTH{1'b0}}, MINV};

    logic [0:0]         state_q, state_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d;
    logic [WIDTH:0]     mplier_q, mplier_d, mag0, mag1;
    logic [SHW:0]       cnt_q, cnt_d;
    logic               sign_q, sign_d, mfwe_q, mfwe_d, mul_done, mul_ovf;
    logic [WIDTH-1:0]   mul_res;

    assign is_mul   = op == OP_MUL;
    assign in_ready = state_q == IDLE;
    assign mag0     = src0[WIDTH-1] ? -{src0[WIDTH-1], src0} : {1'b0, src0};
    assign mag1     = src1[WIDTH-1] ? -{src1[WIDTH-1], src1} : {1'b0, src1};

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        mfwe_d   = mfwe_q;
        if (accept && is_mul) begin
            state_d  = BUSY;
            mcand_d  = {{(WIDTH-1){1'b0}}, mag0};
            acc_d    = '0;
            mplier_d = mag1;
            cnt_d    = (SHW+1)'(WIDTH);
            sign_d   = src0[WIDTH-1] ^ src1[WIDTH-1];
            mfwe_d   = flag_we;
        end else if (state_q == BUSY) begin
            acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - (SHW+1)'(1);
            state_d  = cnt_q == (SHW+1)'(1) ? IDLE : BUSY;
        end
    end

    // The final partial product is folded in on the same edge that registers the result.
    assign mul_done = state_q == BUSY && cnt_q == (SHW+1)'(1);
    assign mul_ovf  = sign_q ? acc_d > HALF : acc_d >= HALF;
    assign mul_res  = mul_ovf ? (sign_q ? MINV : MAXV) : sign_q ? -acc_d[WIDTH-1:0] : acc_d[WIDTH-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            mfwe_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            mfwe_q   <= mfwe_d;
        end
    end
`else
    assign is_mul   = 1'b0;
    assign in_ready = 1'b1;
`endif

    always_comb begin
        dst_d       = dst_q;
        flags_d     = flags_q;
        out_valid_d = 1'b0;
        if (accept && !is_mul) begin
            dst_d       = alu_res;
            out_valid_d = 1'b1;
            if (flag_we && is_arith)
                flags_d = {alu_res[WIDTH-1], alu_res == '0, sat_pos | sat_neg};
            else if (flag_we && is_logic)
                flags_d = {flags_q[2], alu_res == '0, flags_q[0]};
        end
`ifdef SAT_ALU_MUL_EN
        if (mul_done) begin
            dst_d       = mul_res;
            out_valid_d = 1'b1;
            flags_d     = mfwe_q ? {mul_res[WIDTH-1], mul_res == '0, mul_ovf} : flags_q;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_q       <= '0;
            flags_q     <= 3'b000;
            out_valid_q <= 1'b0;
        end else begin
            dst_q       <= dst_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign dst       = dst_q;
    assign flags     = flags_q;
    assign out_valid = out_valid_q;
endmodule

// File: tb/tb_sat_alu_seq.sv
// tb_sat_alu_seq: scoreboard bench for sat_alu_seq at WIDTH=16; MUL checks follow SAT_ALU_MUL_EN.
module tb_sat_alu_seq;
    logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, flag_we = 1'b0;
    logic        in_ready, out_valid;
    logic [3:0]  op = 4'd0, shamt = 4'd0;
    logic [15:0] src0 = 16'h0, src1 = 16'h0, dst;
    logic [2:0]  flags;
    int          total = 0, bad = 0;

    typedef struct {
        logic [15:0] d;
        logic [2:0]  f;
    } exp_t;
    exp_t        q[$];
    exp_t        e;
    logic [15:0] mdst = 16'h0;
    logic [2:0]  mflags = 3'b000;

    sat_alu_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
        .src0(src0), .src1(src1), .shamt(shamt), .flag_we(flag_we),
        .out_valid(out_valid), .dst(dst), .flags(flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) chk("spurious_out_valid", out_valid, 0);
            else begin
                e = q.pop_front();
                chk("dst", dst, e.d);
                chk("flags", flags, e.f);
            end
        end
    end

    function automatic void model(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                  input logic [3:0] sh, input logic we);
        int s;
        logic [15:0] r;
        logic v;
        r = mdst;
        v = 1'b0;
        s = 0;
        case (o)
            4'd0, 4'd1: begin
                s = (o == 4'd0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
                v = (s > 32767) || (s < -32768);
                r = s > 32767 ? 16'h7FFF : s < -32768 ? 16'h8000 : s[15:0];
            end
            4'd2: r = a & b;
            4'd3: r = ~(a | b);
            4'd4: r = a << sh;
            4'd5: r = a >> sh;
            4'd6: begin s = int'($signed(a)) >>> sh; r = s[15:0]; end
            4'd7: r = {b[7:0], a[7:0]};
            default: ;
        endcase
        if (we && o <= 4'd1) mflags = {r[15], r == 16'h0, v};
        else if (we && o >= 4'd2 && o <= 4'd6) mflags[1] = (r == 16'h0);
        mdst = r;
    endfunction

    task automatic issue(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] sh, input logic we, input logic [15:0] ed, input logic [2:0] ef);
        int n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        in_valid = 1'b1; op = o; src0 = a; src1 = b; shamt = sh; flag_we = we;
        q.push_back('{ed, ef});
        mdst = ed;
        mflags = ef;
        @(posedge clk); #1;
    endtask

    task automatic issue_rand();
        logic [3:0] o, sh;
        logic [15:0] a, b;
        logic we;
        o = 4'($urandom_range(0, 15));
        if (o == 4'd8) o = 4'd9;
        a = 16'($urandom);
        b = 16'($urandom);
        sh = 4'($urandom_range(0, 15));
        we = 1'($urandom_range(0, 1));
        model(o, a, b, sh, we);
        issue(o, a, b, sh, we, mdst, mflags);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(posedge clk); #1;
        chk("reset_dst", dst, 16'h0);
        chk("reset_flags", flags, 3'b000);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        issue(4'd0, 16'h7000, 16'h2000, 4'd0, 1'b1, 16'h7FFF, 3'b001);
        issue(4'd1, 16'h8000, 16'h0001, 4'd0, 1'b1, 16'h8000, 3'b101);
        issue(4'd1, 16'h0005, 16'h0005, 4'd0, 1'b1, 16'h0000, 3'b010);
        issue(4'd1, 16'h8000, 16'h0001, 4'd0, 1'b1, 16'h8000, 3'b101);
        issue(4'd6, 16'h8004, 16'h0000, 4'd2, 1'b1, 16'hE001, 3'b101);
        issue(4'd7, 16'h12AB, 16'h00CD, 4'd0, 1'b1, 16'hCDAB, 3'b101);
        issue(4'd2, 16'hF0F0, 16'hFF00, 4'd0, 1'b1, 16'hF000, 3'b101);
        issue(4'd3, 16'hFFFF, 16'h0000, 4'd0, 1'b1, 16'h0000, 3'b111);
        issue(4'd4, 16'h0001, 16'h0000, 4'd15, 1'b0, 16'h8000, 3'b111);
        issue(4'd5, 16'h8000, 16'h0000, 4'd15, 1'b1, 16'h0001, 3'b101);
        issue(4'd6, 16'h8004, 16'h0000, 4'd0, 1'b1, 16'h8004, 3'b101);
        issue(4'd9, 16'h1234, 16'h5678, 4'd3, 1'b1, 16'h8004, 3'b101);
        issue(4'd0, 16'h8000, 16'h8000, 4'd0, 1'b1, 16'h8000, 3'b101);
        issue(4'd1, 16'h0000, 16'h8000, 4'd0, 1'b1, 16'h7FFF, 3'b001);
        issue(4'd1, 16'hFFFF, 16'h8000, 4'd0, 1'b1, 16'h7FFF, 3'b000);
        issue(4'd0, 16'h0005, 16'hFFFB, 4'd0, 1'b0, 16'h0000, 3'b000);
`ifdef SAT_ALU_MUL_EN
        issue(4'd8, 16'hFFFD, 16'h0005, 4'd0, 1'b1, 16'hFFF1, 3'b100);
        in_valid = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            chk("mul_busy_in_ready", in_ready, 0);
            chk("mul_busy_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        chk("mul_done_in_ready", in_ready, 1);
        chk("mul_done_out_valid", out_valid, 1);
        issue(4'd8, 16'h0100, 16'h0100, 4'd0, 1'b1, 16'h7FFF, 3'b001);
        in_valid = 1'b0;
        issue(4'd8, 16'h8000, 16'hFFFF, 4'd0, 1'b1, 16'h7FFF, 3'b001);
        op = 4'd0; src0 = 16'h0001; src1 = 16'h0001;
        repeat (3) @(posedge clk);
        #1 in_valid = 1'b0;
        issue(4'd8, 16'h8000, 16'h0001, 4'd0, 1'b1, 16'h8000, 3'b100);
        in_valid = 1'b0;
        issue(4'd8, 16'h0003, 16'h0003, 4'd0, 1'b1, 16'h0009, 3'b000);
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b1;
        void'(q.pop_back());
        #1;
        chk("mulrst_dst", dst, 16'h0);
        chk("mulrst_flags", flags, 3'b000);
        chk("mulrst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        issue(4'd0, 16'h0001, 16'h0001, 4'd0, 1'b1, 16'h0002, 3'b000);
`else
        issue(4'd8, 16'h0100, 16'h0100, 4'd0, 1'b1, 16'h0000, 3'b000);
        chk("nomul_in_ready", in_ready, 1);
`endif
        in_valid = 1'b0;
        for (int n = 0; n < 50 && q.size() > 0; n++) @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("async_rst_dst", dst, 16'h0);
        chk("async_rst_flags", flags, 3'b000);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_out_valid", out_valid, 0);
        mdst = 16'h0;
        mflags = 3'b000;
        @(posedge clk); #1;
        rst = 1'b0;
        issue(4'd0, 16'h0001, 16'h0001, 4'd0, 1'b1, 16'h0002, 3'b000);
        for (int i = 0; i < 60; i++) issue_rand();
        in_valid = 1'b0;
        for (int n = 0; n < 50 && q.size() > 0; n++) @(posedge clk);
        chk("drain", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
